// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for the write side of one async FIFO
//
// Shares one FIFO write port among NUM_REQ producers in the write clock
// domain. A producer raises req_i and is granted a burst of up to MAX_BURST
// words. While it holds the grant, its words pass straight through to the FIFO
// through a valid/ready handshake, throttled by wfull_i. When one burst ends,
// the next grant is loaded on the same edge, so there is no idle cycle
// between bursts.
//
// Optional feature macro: FIFO_ARB_STATS_EN (per-requester accepted-word counters).
//
// Parameters:
//   DATA_LEN    word width, matches the FIFO
//   NUM_REQ     number of requesters (2..8)
//   MAX_BURST   maximum words per grant (>= 1)
//
// Ports:
//   wclk         write-domain clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        per-requester request, level-held while data is pending
//   valid_i      per-requester word valid
//   data_i       requester n's word in [n*DATA_LEN +: DATA_LEN]
//   ready_o      per-requester ready; a word moves on valid_i[n] & ready_o[n]
//   gnt_o        one-hot registered grant, or zero when idle
//   wfull_i      FIFO full flag
//   write_en_o   FIFO write enable
//   wdata_o      FIFO write data
//   busy_o       high while a burst is granted
//   stats_clr_i  synchronous clear of the statistics counters
//   word_cnt_o   per-requester 16-bit accepted-word counters, saturating

module fifo_write_arbiter #(
    parameter int DATA_LEN  = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        wclk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          valid_i,
    input  logic [NUM_REQ*DATA_LEN-1:0] data_i,
    output logic [NUM_REQ-1:0]          ready_o,
    output logic [NUM_REQ-1:0]          gnt_o,
    input  logic                        wfull_i,
    output logic                        write_en_o,
    output logic [DATA_LEN-1:0]         wdata_o,
    output logic                        busy_o,
    input  logic                        stats_clr_i,
    output logic [NUM_REQ*16-1:0]       word_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   last;
    logic [CNT_W-1:0]   cnt;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_onehot;

    logic [NUM_REQ-1:0] accept;
    logic               word_taken;
    logic               grant_live;
    logic               burst_end;

    // Round-robin scan starting just after the last granted index and
    // wrapping. Inside a burst, last already holds the current grantee, so
    // the same scan serves both the IDLE pick and the end-of-burst handover.
    // The current grantee is visited last, so it is re-granted only when
    // nobody else is requesting.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int               k;
            logic [IDX_W-1:0] kk;
            k  = (int'(last) + i) % NUM_REQ;
            kk = IDX_W'(k);
            if (!arb_found && req_i[kk]) begin
                arb_found = 1'b1;
                arb_idx   = kk;
            end
        end
    end

    assign arb_onehot = NUM_REQ'(1) << arb_idx;

    // Data path is purely combinational from the registered grant, so a
    // granted word reaches the FIFO in the same cycle. A zero grant (idle or
    // in reset) forces every output low, which also drops any word in flight
    // the moment reset is asserted.
    assign ready_o    = gnt & {NUM_REQ{~wfull_i}};
    assign accept     = ready_o & valid_i;
    assign word_taken = |accept;
    assign write_en_o = word_taken;
    assign gnt_o      = gnt;
    assign busy_o     = (state == ST_BURST);

    // One-hot OR-mux. This gives zero when nothing is granted.
    always_comb begin
        wdata_o = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (gnt[n]) begin
                wdata_o = wdata_o | data_i[n*DATA_LEN +: DATA_LEN];
            end
        end
    end

    // The burst closes on its final word, or when the grantee withdraws its
    // request in a cycle with no transfer. A full FIFO alone never closes it.
    assign grant_live = |(req_i & gnt);
    assign burst_end  = (word_taken && (cnt == CNT_LAST)) ||
                        (!grant_live && !word_taken);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= LAST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        state <= ST_BURST;
                        gnt   <= arb_onehot;
                        last  <= arb_idx;
                        cnt   <= '0;
                    end
                end
                ST_BURST: begin
                    if (burst_end) begin
                        cnt <= '0;
                        if (arb_found) begin
                            gnt  <= arb_onehot;
                            last <= arb_idx;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end else if (word_taken) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating per-requester counters. A clear wins over a same-cycle increment.
    for (genvar n = 0; n < NUM_REQ; n++) begin : g_stats
        logic [15:0] word_cnt;

        always_ff @(posedge wclk or negedge rst_n) begin
            if (!rst_n) begin
                word_cnt <= '0;
            end else if (stats_clr_i) begin
                word_cnt <= '0;
            end else if (accept[n] && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end

        assign word_cnt_o[n*16 +: 16] = word_cnt;
    end
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr_i;
    assign word_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter with a grant-level reference model

module tb_fifo_write_arbiter;

    localparam int DL = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    logic             wclk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_i;
    logic [NR-1:0]    valid_i;
    logic [NR*DL-1:0] data_i;
    logic [NR-1:0]    ready_o;
    logic [NR-1:0]    gnt_o;
    logic             wfull_i;
    logic             write_en_o;
    logic [DL-1:0]    wdata_o;
    logic             busy_o;
    logic             stats_clr_i;
    logic [NR*16-1:0] word_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the bus, how many words it has moved in this
    // burst, who held it last, and how many words each producer has delivered.
    int m_g;
    int m_last;
    int m_words_in_burst;
    int m_total[NR];

    fifo_write_arbiter #(.DATA_LEN(DL), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .gnt_o       (gnt_o),
        .wfull_i     (wfull_i),
        .write_en_o  (write_en_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o),
        .stats_clr_i (stats_clr_i),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int from);
        for (int i = 1; i <= NR; i++) begin
            if (r[(from + i) % NR]) return (from + i) % NR;
        end
        return -1;
    endfunction

    task automatic reset_model();
        m_g              = -1;
        m_last           = NR - 1;
        m_words_in_burst = 0;
        for (int n = 0; n < NR; n++) m_total[n] = 0;
    endtask

    function automatic logic [NR*16-1:0] exp_counts();
        logic [NR*16-1:0] v;
        v = '0;
`ifdef FIFO_ARB_STATS_EN
        for (int n = 0; n < NR; n++) v[n*16 +: 16] = 16'(m_total[n]);
`endif
        return v;
    endfunction

    // One clock cycle: apply inputs after the edge, compare at the falling
    // edge, then advance the model on the rising edge.
    task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] v,
                         input logic f, input logic c);
        logic          acc;
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rdy;
        logic [DL-1:0] e_data;
        logic          fin;
        req_i       = r;
        valid_i     = v;
        wfull_i     = f;
        stats_clr_i = c;
        data_i      = {$urandom, $urandom, $urandom, $urandom};
        @(negedge wclk);
        e_gnt  = (m_g >= 0) ? NR'(1) << m_g : '0;
        e_rdy  = f ? '0 : e_gnt;
        acc    = (m_g >= 0) && v[m_g] && !f;
        e_data = (m_g >= 0) ? data_i[m_g*DL +: DL] : '0;
        check("gnt", gnt_o, e_gnt);
        check("ready", ready_o, e_rdy);
        check("write_en", write_en_o, acc);
        check("wdata", wdata_o, e_data);
        check("busy", busy_o, m_g >= 0);
        check("word_cnt", word_cnt_o, exp_counts());
        @(posedge wclk);
        if (c) begin
            for (int n = 0; n < NR; n++) m_total[n] = 0;
        end else if (acc && m_total[m_g] < 65535) begin
            m_total[m_g]++;
        end
        if (m_g < 0) begin
            m_g = pick(r, m_last);
            if (m_g >= 0) m_last = m_g;
            m_words_in_burst = 0;
        end else begin
            if (acc) m_words_in_burst++;
            fin = (acc && m_words_in_burst == MB) || (!r[m_g] && !acc);
            if (fin) begin
                m_last           = m_g;
                m_g              = pick(r, m_last);
                if (m_g >= 0) m_last = m_g;
                m_words_in_burst = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [NR-1:0] rr;
        rst_n       = 1'b0;
        req_i       = '0;
        valid_i     = '0;
        wfull_i     = 1'b0;
        stats_clr_i = 1'b0;
        data_i      = '0;
        reset_model();
        repeat (2) @(posedge wclk);
        #2;
        check("rst_gnt", gnt_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_wen", write_en_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wcnt", word_cnt_o, 0);
        @(negedge wclk);
        rst_n = 1'b1;
        @(posedge wclk);
        #1;

        // Single requester: first grant, burst of MB, back-to-back re-grant, drop.
        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("single_first_gnt", gnt_o, 4'b0001);
        repeat (6) drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("single_idle_gnt", gnt_o, 4'b0000);
        check("single_idle_busy", busy_o, 1'b0);

        // Rotation with everyone requesting continuously.
        repeat (21) drive(4'b1111, 4'b1111, 1'b0, 1'b0);

        // Asynchronous reset mid-burst, between edges.
        rst_n = 1'b0;
        #2;
        check("midrst_gnt", gnt_o, 0);
        check("midrst_wen", write_en_o, 0);
        check("midrst_ready", ready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_wdata", wdata_o, 0);
        check("midrst_wcnt", word_cnt_o, 0);
        reset_model();
        req_i   = '0;
        valid_i = '0;
        @(negedge wclk);
        rst_n = 1'b1;
        @(posedge wclk);
        #1;
        drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        check("post_rst_gnt", gnt_o, 4'b0001);

        // Full stall at two words into the burst.
        repeat (2) drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        repeat (5) drive(4'b1111, 4'b1111, 1'b1, 1'b0);
        check("stall_gnt_held", gnt_o, 4'b0001);
        repeat (2) drive(4'b1111, 4'b1111, 1'b0, 1'b0);
        check("stall_rotate", gnt_o, 4'b0010);

        // Statistics: five words from requester 2, then clear during a write.
        repeat (2) drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat (6) drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
`ifdef FIFO_ARB_STATS_EN
        check("stats_five", word_cnt_o[2*16 +: 16], 16'd5);
`else
        check("stats_off", word_cnt_o, 0);
`endif
        drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        check("stats_clr", word_cnt_o[2*16 +: 16], 16'd0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Early drop: requester 1 leaves after one word, requester 3 waits,
        // and requester 2 asserts valid without a grant.
        drive(4'b0010, 4'b0110, 1'b0, 1'b0);
        check("drop_gnt1", gnt_o, 4'b0010);
        drive(4'b0010, 4'b0110, 1'b0, 1'b0);
        drive(4'b1000, 4'b0100, 1'b0, 1'b0);
        check("drop_gnt3", gnt_o, 4'b1000);
        check("drop_no_wen", write_en_o, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Randomized traffic with sticky requests, stalls and clears.
        rr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < NR; n++) begin
                if ($urandom_range(0, 7) == 0) rr[n] = ~rr[n];
            end
            drive(rr, NR'($urandom) | NR'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares the write side of one `async_fifo` instance among `NUM_REQ` producers in the write clock domain. Each producer requests, is granted a burst of up to `MAX_BURST` words, and pushes data through a valid/ready handshake. The arbiter drives the FIFO's `write_en`/`data_in` and throttles on `full`. It sits between the producers and `async_fifo_wrapper`'s `write_en`, `wdata_i` and `wfull_o`.

## Interface
- `DATA_LEN`, 32, word width; matches the FIFO.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `MAX_BURST`, 4, maximum words per grant, ≥1.
- `wclk` input 1: write-domain clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_i` input NUM_REQ: per-requester request, level-held while the requester has data.
- `valid_i` input NUM_REQ: per-requester word valid.
- `data_i` input NUM_REQ*DATA_LEN: requester n's word is in slice [n*DATA_LEN +: DATA_LEN].
- `ready_o` output NUM_REQ: word accepted when `valid_i[n] & ready_o[n]`.
- `gnt_o` output NUM_REQ: one-hot registered grant, or zero.
- `wfull_i` input 1: FIFO full flag.
- `write_en_o` output 1: FIFO write enable.
- `wdata_o` output DATA_LEN: FIFO write data.
- `busy_o` output 1: high in BURST.
- `stats_clr_i` input 1: clears the statistics counters.
- `word_cnt_o` output NUM_REQ*16: per-requester accepted-word counters.

## Operation
- **FSM states:** IDLE, BURST.
- **Registered state:**
  - `gnt` (one-hot).
  - `last`: index of the last granted requester.
  - `cnt`: width $clog2(MAX_BURST+1), counts words accepted in the current burst.
- **Arbitration function:** scan `req_i` starting at index (`last`+1) mod NUM_REQ, wrapping around. The first set bit wins.
- **IDLE:**
  - If any `req_i` is set: register the winner into `gnt` and `last`, clear `cnt`, go to BURST.
  - Otherwise stay in IDLE.
- **BURST, granted requester g:**
  - `ready_o[g]` = ~`wfull_i`. All other `ready_o` bits are 0.
  - `write_en_o` = `valid_i[g]` & ~`wfull_i`.
  - `wdata_o` = slice g of `data_i`.
  - Each accepted word increments `cnt`.
- **Burst end:** the burst ends on either condition, evaluated each cycle:
  - (a) a word is accepted and `cnt` == MAX_BURST-1;
  - (b) `req_i[g]` is 0 and no word is accepted this cycle.
- **On burst end:**
  - Run the arbitration function in the same cycle, with `last` = g.
  - If a winner exists, load the new `gnt`, clear `cnt` and stay in BURST. There is no bubble cycle.
  - Otherwise clear `gnt` and go to IDLE.
  - g is re-granted only if no other requester is requesting.
- **Full:** while `wfull_i` = 1, nothing is accepted and `cnt` holds. A full FIFO never ends a burst by itself; condition (b) still applies.
- **Ignored inputs:** `valid_i` from non-granted requesters is ignored. `valid_i[g]` with `req_i[g]` = 0 still writes the word, if not full.
- **Reset values (`rst_n` low, at any time including mid-burst):**
  - state IDLE, `gnt_o` = 0, `cnt` = 0, `last` = NUM_REQ-1, so requester 0 wins first.
  - `ready_o` = 0, `write_en_o` = 0, `wdata_o` = 0, `busy_o` = 0, `word_cnt_o` = 0.
  - A word in flight at reset assertion is not written.

## Timing
- Request latency: `req_i[n]` rising at edge k → `gnt_o[n]` = 1 after edge k+1. The first write is possible in that cycle.
- `write_en_o`, `wdata_o` and `ready_o` are combinational from `gnt`, `valid_i`, `data_i` and `wfull_i`. Write latency is 0 cycles inside a grant.
- Back-to-back grants: the new grant takes effect on the edge that ends the previous burst. The bus achieves 1 word/cycle across grants.
- Maximum wait for a continuously requesting producer: (NUM_REQ-1)*MAX_BURST accepted words, plus any full-stall cycles.

## Configuration
- Macro: `FIFO_ARB_STATS_EN`.
- **Defined:**
  - `word_cnt_o[n*16 +: 16]` increments on every accepted word from requester n.
  - The counter saturates at 16'hFFFF.
  - `stats_clr_i` = 1 synchronously zeroes all counters. Clear has priority over an increment in the same cycle.
- **Undefined:** the ports remain, `word_cnt_o` is tied to 0, `stats_clr_i` is ignored, and no counter flops are built.

## Test plan
- **Single requester:** after reset, `req_i` = 4'b0001 with valid held for 6 words, `wfull_i` = 0.
  - Required: `gnt_o` = 0001 one cycle later.
  - Writes of words 0-3, then a re-grant to requester 0 with no bubble, then words 4-5.
  - `req_i` dropped → IDLE, `gnt_o` = 0.
- **Rotation:** `req_i` = 4'b1111, all valid continuously.
  - Required: grant order 0,1,2,3,0, 4 writes each, `write_en_o` high every cycle after the first grant.
- **Full stall:** mid-burst with `cnt` = 2, `wfull_i` = 1 for 5 cycles.
  - Required: `ready_o` = 0, `write_en_o` = 0, `cnt` holds at 2, grant unchanged.
  - After release: 2 more words, then the grant rotates.
- **Early drop:** requester 1 granted, 1 word written, then `req_i[1]` = 0 and `valid_i[1]` = 0, with `req_i[3]` = 1.
  - Required: `gnt_o` = 1000 on the next edge.
  - Non-granted `valid_i[2]` = 1 never produces a write.
- **Reset mid-burst:** `rst_n` pulsed low asynchronously between edges during a burst.
  - Required: outputs go to reset values immediately.
  - After release with `req_i` = 1111, requester 0 is granted first.
- **Statistics, with `FIFO_ARB_STATS_EN`:**
  - 5 words from requester 2 → `word_cnt_o` slice 2 = 5.
  - `stats_clr_i` pulsed in the same cycle as a write → 0.
  - Without the macro, `word_cnt_o` = 0 throughout.
